// File: rtl/hdmi_pattern_pkg.sv
// Shared definitions for the HDMI test-pattern generator: pattern mode
// codes, box motion direction encoding, and the colour constants used by
// the border, bar and box patterns.
package hdmi_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BORDER = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_RAMP   = 2'd2,
    MODE_BOX    = 2'd3
  } mode_e;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  localparam logic [23:0] C_BLACK       = 24'h000000;
  localparam logic [23:0] C_BORDER_LEFT = 24'hFF0000;
  localparam logic [23:0] C_BORDER_TOP  = 24'h00FF00;
  localparam logic [23:0] C_BORDER_EDGE = 24'h0000FF;
  localparam logic [23:0] C_BOX_FG      = 24'hFFFFFF;
  localparam logic [23:0] C_BOX_BG      = 24'h000040;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hdmi_pattern_gen_box_motion.sv
// One axis of the bouncing box. Steps the box position by STEP once per
// frame (step_en), reflecting off 0 and off (limit - SIZE).
// Ports:
//   clk_pixel  pixel clock
//   reset_n    async active-low reset (pos=0, dir=positive)
//   step_en    frame-boundary strobe
//   limit      screen dimension along this axis
//   pos        current box origin along this axis
//   dir        current direction (DIR_POS / DIR_NEG)
module box_motion
  import hdmi_pattern_pkg::*;
#(
  parameter int SIZE = 64,
  parameter int STEP = 2
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        step_en,
  input  logic [11:0] limit,
  output logic [11:0] pos,
  output logic        dir
);

  logic [11:0] r_pos;
  logic        r_dir;
  logic [12:0] w_pos13;
  logic [12:0] w_lim13;

  // 13-bit views so pos + SIZE + STEP cannot wrap.
  assign w_pos13 = {1'b0, r_pos};
  assign w_lim13 = {1'b0, limit};

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_pos <= '0;
      r_dir <= DIR_POS;
    end else if (step_en) begin
      if (w_lim13 <= 13'(SIZE)) begin
        // Screen no larger than the box: park it.
        r_pos <= '0;
        r_dir <= DIR_POS;
      end else if (r_dir == DIR_POS) begin
        if (w_pos13 + 13'(SIZE + STEP) >= w_lim13) begin
          r_pos <= 12'(w_lim13 - 13'(SIZE));
          r_dir <= DIR_NEG;
        end else begin
          r_pos <= r_pos + 12'(STEP);
        end
      end else begin
        if (w_pos13 <= 13'(STEP)) begin
          r_pos <= '0;
          r_dir <= DIR_POS;
        end else begin
          r_pos <= r_pos - 12'(STEP);
        end
      end
    end
  end

  assign pos = r_pos;
  assign dir = r_dir;

endmodule

// File: rtl/hdmi_pattern_gen.sv
// Test-pattern pixel source for the HDMI core. Follows the core's cx/cy
// and produces a registered rgb one clock later.
// Ports:
//   clk_pixel, reset_n           pixel clock, async active-low reset
//   mode                         pattern select, taken at end of frame
//   cx, cy                       current pixel coordinates
//   screen_width, screen_height  active area size
//   rgb                          {R,G,B}, 1-cycle latency from cx/cy
//   frame_start                  pulse for the first (0,0) pixel of a frame
//   frame_count                  completed frames, wrapping
module hdmi_pattern_gen
  import hdmi_pattern_pkg::*;
#(
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 2,
  parameter int FCNT_W   = 16
) (
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic [11:0]       cx,
  input  logic [11:0]       cy,
  input  logic [11:0]       screen_width,
  input  logic [11:0]       screen_height,
  output logic [23:0]       rgb,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_count
);

  logic [12:0] w_cx13, w_cy13, w_sw13, w_sh13;
  logic        w_last_x, w_last_y, w_eof, w_active, w_origin;
  logic [11:0] w_bx, w_by;
  logic        w_bx_dir, w_by_dir;
  logic [1:0]  w_unused_dirs;
  logic [11:0] w_bar_w;
  logic [2:0]  w_cur_bar;
  logic [11:0] w_cur_seg;
  logic [7:0]  w_ramp;
  logic        w_in_box;
  logic [23:0] w_pix;

  mode_e             r_mode;
  logic [FCNT_W-1:0] r_frame_count;
  logic              r_frame_start;
  logic              r_prev_origin;
  logic [23:0]       r_rgb;
  logic [2:0]        r_bar;
  logic [11:0]       r_seg;

  assign w_cx13   = {1'b0, cx};
  assign w_cy13   = {1'b0, cy};
  assign w_sw13   = {1'b0, screen_width};
  assign w_sh13   = {1'b0, screen_height};
  assign w_last_x = (w_cx13 == w_sw13 - 13'd1);
  assign w_last_y = (w_cy13 == w_sh13 - 13'd1);
  assign w_eof    = w_last_x && w_last_y;
  assign w_active = (w_cx13 < w_sw13) && (w_cy13 < w_sh13);
  assign w_origin = (cx == 12'd0) && (cy == 12'd0);

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_mode        <= MODE_BORDER;
      r_frame_count <= '0;
      r_frame_start <= 1'b0;
      r_prev_origin <= 1'b0;
    end else begin
      // Pulse only on the first cycle at (0,0), even if the origin is held.
      r_frame_start <= w_origin && !r_prev_origin;
      r_prev_origin <= w_origin;
      if (w_eof) begin
        r_frame_count <= r_frame_count + 1'b1;
        r_mode        <= mode_e'(mode);
      end
    end
  end

  box_motion #(.SIZE(BOX_SIZE), .STEP(BOX_STEP)) u_box_x (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .step_en(w_eof),
    .limit(screen_width), .pos(w_bx), .dir(w_bx_dir)
  );

  box_motion #(.SIZE(BOX_SIZE), .STEP(BOX_STEP)) u_box_y (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .step_en(w_eof),
    .limit(screen_height), .pos(w_by), .dir(w_by_dir)
  );

  assign w_unused_dirs = {w_bx_dir, w_by_dir};

  // Bars: counter tracks position within the current bar; cx==0 forces
  // bar 0 so each line restarts regardless of what the previous line did.
  assign w_bar_w   = {3'b000, screen_width[11:3]};
  assign w_cur_bar = (cx == 12'd0) ? 3'd0  : r_bar;
  assign w_cur_seg = (cx == 12'd0) ? 12'd0 : r_seg;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_bar <= '0;
      r_seg <= '0;
    end else if ((w_cur_bar != 3'd7) && (w_cur_seg + 12'd1 == w_bar_w)) begin
      r_bar <= w_cur_bar + 3'd1;
      r_seg <= '0;
    end else begin
      r_bar <= w_cur_bar;
      r_seg <= w_cur_seg + 12'd1;
    end
  end

  assign w_ramp   = cx[7:0] + r_frame_count[7:0];
  assign w_in_box = (w_cx13 >= {1'b0, w_bx}) && (w_cx13 < {1'b0, w_bx} + 13'(BOX_SIZE)) &&
                    (w_cy13 >= {1'b0, w_by}) && (w_cy13 < {1'b0, w_by} + 13'(BOX_SIZE));

  always_comb begin
    w_pix = C_BLACK;
    case (r_mode)
      MODE_BORDER: begin
        if (cx == 12'd0)             w_pix = C_BORDER_LEFT;
        else if (cy == 12'd0)        w_pix = C_BORDER_TOP;
        else if (w_last_x || w_last_y) w_pix = C_BORDER_EDGE;
        else                         w_pix = C_BLACK;
      end
      MODE_BARS: w_pix = bar_colour(w_cur_bar);
      MODE_RAMP: w_pix = {w_ramp, w_ramp, w_ramp};
      MODE_BOX:  w_pix = w_in_box ? C_BOX_FG : C_BOX_BG;
      default:   w_pix = C_BLACK;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) r_rgb <= C_BLACK;
    else          r_rgb <= w_active ? w_pix : C_BLACK;
  end

  assign rgb         = r_rgb;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
module tb_hdmi_pattern_gen;

  localparam int SW   = 640;
  localparam int SH   = 480;
  localparam int BOX  = 64;
  localparam int STEP = 2;

  logic        clk_pixel = 1'b0;
  logic        reset_n   = 1'b0;
  logic [1:0]  mode      = 2'd0;
  logic [11:0] cx        = 12'd0;
  logic [11:0] cy        = 12'd0;
  logic [11:0] screen_width  = 12'd640;
  logic [11:0] screen_height = 12'd480;
  logic [23:0] rgb;
  logic        frame_start;
  logic [15:0] frame_count;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_pattern_gen #(.BOX_SIZE(64), .BOX_STEP(2), .FCNT_W(16)) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .mode(mode), .cx(cx), .cy(cy),
    .screen_width(screen_width), .screen_height(screen_height),
    .rgb(rgb), .frame_start(frame_start), .frame_count(frame_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_mode, m_fc, m_bx, m_by, m_px, m_py;
  bit m_xup, m_yup, m_prev_origin, m_contig;

  logic [23:0] bar_lut [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [23:0] obs_line [0:799];

  function automatic logic [23:0] model_rgb(input int x, input int y);
    int b;
    logic [7:0] v;
    if (x >= SW || y >= SH) return 24'h0;
    case (m_mode)
      0: begin
        if (x == 0) return 24'hFF0000;
        if (y == 0) return 24'h00FF00;
        if (x == SW - 1 || y == SH - 1) return 24'h0000FF;
        return 24'h0;
      end
      1: begin
        b = x / (SW / 8);
        if (b > 7) b = 7;
        return bar_lut[b];
      end
      2: begin
        v = 8'((x + m_fc) % 256);
        return {v, v, v};
      end
      default: begin
        if (x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX) return 24'hFFFFFF;
        return 24'h000040;
      end
    endcase
  endfunction

  task automatic step_axis(inout int pos, inout bit up, input int lim);
    if (lim <= BOX) begin
      pos = 0; up = 1'b1;
    end else if (up) begin
      if (pos + BOX + STEP >= lim) begin pos = lim - BOX; up = 1'b0; end
      else pos = pos + STEP;
    end else begin
      if (pos <= STEP) begin pos = 0; up = 1'b1; end
      else pos = pos - STEP;
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_fc = 0; m_bx = 0; m_by = 0; m_xup = 1'b1; m_yup = 1'b1;
    m_prev_origin = 1'b0; m_contig = 1'b0; m_px = -2; m_py = -2;
  endtask

  task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present one pixel, clock it, check outputs one cycle later against the model.
  task automatic drive(input int x, input int y);
    logic [23:0] e_rgb;
    bit e_fs, e_eof, contig, chk_rgb;
    e_rgb  = model_rgb(x, y);
    contig = (x == 0) || (m_contig && x == m_px + 1 && y == m_py);
    // The bar pattern is only defined for lines scanned from cx=0.
    chk_rgb = !(m_mode == 1 && x < SW && y < SH && !contig);
    e_fs  = (x == 0 && y == 0) && !m_prev_origin;
    e_eof = (x == SW - 1) && (y == SH - 1);
    cx = 12'(x);
    cy = 12'(y);
    @(posedge clk_pixel);
    #1;
    if (e_eof) begin
      m_fc   = (m_fc + 1) % 65536;
      m_mode = int'(mode);
      step_axis(m_bx, m_xup, SW);
      step_axis(m_by, m_yup, SH);
    end
    m_prev_origin = (x == 0 && y == 0);
    m_contig = contig;
    m_px = x;
    m_py = y;
    if (x >= 0 && x < 800) obs_line[x] = rgb;
    if (chk_rgb) chk24("rgb_model", rgb, e_rgb);
    chk1("frame_start_model", frame_start, e_fs);
    chk16("frame_count_model", frame_count, 16'(m_fc));
  endtask

  task automatic scan_line(input int y, input int xe);
    for (int x = 0; x <= xe; x++) drive(x, y);
  endtask

  task automatic eof();
    drive(SW - 1, SH - 1);
  endtask

  initial begin
    int n, y, xe;
    model_reset();

    // Reset state
    #3;
    chk24("reset_rgb", rgb, 24'h0);
    chk1("reset_frame_start", frame_start, 1'b0);
    chk16("reset_frame_count", frame_count, 16'h0);
    @(negedge clk_pixel);
    reset_n = 1'b1;

    // Border pattern
    drive(0, 5);     chk24("border_0_5", rgb, 24'hFF0000);
    drive(5, 0);     chk24("border_5_0", rgb, 24'h00FF00);
    drive(639, 100); chk24("border_639_100", rgb, 24'h0000FF);
    drive(100, 479); chk24("border_100_479", rgb, 24'h0000FF);
    drive(100, 100); chk24("border_100_100", rgb, 24'h000000);
    drive(700, 10);  chk24("border_700_10", rgb, 24'h000000);

    // Mid-frame switch to bars: no effect until eof
    mode = 2'd1;
    drive(100, 100); chk24("bars_pending_interior", rgb, 24'h000000);
    drive(0, 200);   chk24("bars_pending_left", rgb, 24'hFF0000);
    eof();
    scan_line(10, 639);
    chk24("bars_x0", obs_line[0], 24'hFFFFFF);
    chk24("bars_x79", obs_line[79], 24'hFFFFFF);
    chk24("bars_x80", obs_line[80], 24'hFFFF00);
    chk24("bars_x639", obs_line[639], 24'h000000);

    // Ramp at frame_count 3
    mode = 2'd2;
    eof();
    eof();
    chk16("ramp_fc", frame_count, 16'd3);
    scan_line(20, 255);
    chk24("ramp_x10", obs_line[10], 24'h0D0D0D);
    chk24("ramp_x255", obs_line[255], 24'h020202);

    // Reset pulse mid-frame
    drive(299, 200);
    drive(300, 200);
    #2 reset_n = 1'b0;
    #1;
    chk24("rst_mid_rgb", rgb, 24'h0);
    chk16("rst_mid_fc", frame_count, 16'h0);
    @(posedge clk_pixel);
    #1;
    chk24("rst_hold_rgb", rgb, 24'h0);
    chk16("rst_hold_fc", frame_count, 16'h0);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    model_reset();
    drive(301, 200); chk24("post_rst_mode0", rgb, 24'h000000);
    drive(0, 0);     chk1("post_rst_frame_start", frame_start, 1'b1);
    drive(0, 0);     chk1("held_origin_no_pulse", frame_start, 1'b0);

    // Bouncing box from defaults
    mode = 2'd3;
    eof();
    drive(2, 2);   chk24("box1_corner", rgb, 24'hFFFFFF);
    drive(1, 2);   chk24("box1_left", rgb, 24'h000040);
    drive(2, 1);   chk24("box1_above", rgb, 24'h000040);
    drive(65, 65); chk24("box1_far_corner", rgb, 24'hFFFFFF);
    drive(66, 65); chk24("box1_right", rgb, 24'h000040);
    for (int i = 0; i < 287; i++) eof();
    drive(576, 256); chk24("box288_corner", rgb, 24'hFFFFFF);
    drive(575, 256); chk24("box288_left", rgb, 24'h000040);
    drive(576, 255); chk24("box288_above", rgb, 24'h000040);
    eof();
    drive(574, 254); chk24("box289_corner", rgb, 24'hFFFFFF);
    drive(573, 254); chk24("box289_left", rgb, 24'h000040);

    // Randomised frames, lines and scattered pixels
    for (int it = 0; it < 12; it++) begin
      mode = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) eof();
      y  = $urandom_range(0, 524);
      xe = $urandom_range(0, 799);
      scan_line(y, xe);
      for (int k = 0; k < 20; k++) drive($urandom_range(0, 799), $urandom_range(0, 524));
    end

    // frame_count wrap
    mode = 2'd0;
    while (m_fc != 65535) eof();
    chk16("fc_max", frame_count, 16'hFFFF);
    eof();
    chk16("fc_wrap", frame_count, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
